// File: rtl/draw_pkg.sv
// Shared types and default geometry for the scrolling tilemap renderer.
package draw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAP  = 2'd1,
    ST_CODE = 2'd2,
    ST_PIX  = 2'd3
  } draw_state_t;

  localparam int TILE_LOG2_DEF   = 3;
  localparam int SCREEN_COLS_DEF = 20;
  localparam int MAP_ROWS_DEF    = 15;
  localparam int COLOR_DEPTH_DEF = 9;
  localparam int SCROLL_W        = 14;
  localparam int X_W             = 8;
  localparam int Y_W             = 7;

endpackage

// File: rtl/tile_pixel_stream.sv
// Walks the T*T pixels of one tile, issues tileset addresses and emits the
// clipped, one-cycle-delayed pixel stream.
module tile_pixel_stream
  import draw_pkg::*;
#(
  parameter int TILE_LOG2   = TILE_LOG2_DEF,
  parameter int CODE_W      = 4,
  parameter int COLOR_DEPTH = COLOR_DEPTH_DEF,
  parameter int SCREEN_COLS = SCREEN_COLS_DEF,
  parameter int COL_W       = 5,
  parameter int ROW_W       = 4
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          run,
  input  logic [CODE_W-1:0]             code,
  input  logic [COL_W-1:0]              col,
  input  logic [ROW_W-1:0]              row,
  input  logic [TILE_LOG2-1:0]          fine,
  input  logic [COLOR_DEPTH-1:0]        tile_data,
  output logic [CODE_W+2*TILE_LOG2-1:0] tile_address,
  output logic [X_W-1:0]                x,
  output logic [Y_W-1:0]                y,
  output logic [COLOR_DEPTH-1:0]        color,
  output logic                          plot,
  output logic                          last
);

  localparam int T   = 1 << TILE_LOG2;
  localparam int K_W = 2 * TILE_LOG2;

  logic [K_W-1:0]       k;
  logic [TILE_LOG2-1:0] px;
  logic [TILE_LOG2-1:0] py;
  int                   sx;
  int                   sy;
  logic                 visible;

  assign px = k[TILE_LOG2-1:0];
  assign py = k[K_W-1:TILE_LOG2];

  // Screen x can go negative for the partially scrolled-off left column.
  always_comb begin
    sx      = int'(col) * T + int'(px) - int'(fine);
    sy      = int'(row) * T + int'(py);
    visible = run && (sx >= 0) && (sx < SCREEN_COLS * T);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      k    <= '0;
      plot <= 1'b0;
      x    <= '0;
      y    <= '0;
    end else begin
      k    <= run ? k + K_W'(1) : '0;
      plot <= visible;
      if (run) begin
        x <= X_W'(sx);
        y <= Y_W'(sy);
      end
    end
  end

  assign tile_address = run ? {code, k} : '0;
  assign last         = run && (k == '1);
  // tile_data arrives one cycle after tile_address, i.e. aligned with plot.
  assign color        = plot ? tile_data : '0;

endmodule

// File: rtl/draw_tilemap_scroll.sv
// Draws one screen of a horizontally scrolled tilemap, tile by tile in
// row-major order, skipping tiles whose code is SKIP_CODE.
//
// state | meaning
// IDLE  | waiting for enable, done high
// MAP   | level_address presented for the current tile
// CODE  | tile_code returned and latched; skip tiles advance from here
// PIX   | T*T tileset reads for the current tile
module draw_tilemap_scroll
  import draw_pkg::*;
#(
  parameter int TILEMAP_LEN = 2000,
  parameter int MAP_ROWS    = MAP_ROWS_DEF,
  parameter int SCREEN_COLS = SCREEN_COLS_DEF,
  parameter int TILE_LOG2   = TILE_LOG2_DEF,
  parameter int COLOR_DEPTH = COLOR_DEPTH_DEF,
  parameter int CODE_W      = 4,
  parameter int SKIP_CODE   = 0,
  parameter int ADDR_W      = 15
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic [SCROLL_W-1:0]           scroll_x,
  input  logic [CODE_W-1:0]             tile_code,
  input  logic [COLOR_DEPTH-1:0]        tile_data,
  output logic [ADDR_W-1:0]             level_address,
  output logic [CODE_W+2*TILE_LOG2-1:0] tile_address,
  output logic [X_W-1:0]                x,
  output logic [Y_W-1:0]                y,
  output logic [COLOR_DEPTH-1:0]        color,
  output logic                          plot,
  output logic                          done
);

  localparam int T     = 1 << TILE_LOG2;
  localparam int COL_W = $clog2(SCREEN_COLS + 2);
  localparam int ROW_W = $clog2(MAP_ROWS + 1);
  localparam logic [SCROLL_W-1:0] MAX_SCROLL = SCROLL_W'((TILEMAP_LEN - SCREEN_COLS) * T);

  draw_state_t          state, state_next;
  logic [SCROLL_W-1:0]  scroll_q;
  logic [SCROLL_W-1:0]  scroll_clamped;
  logic [SCROLL_W-1:0]  coarse;
  logic [COL_W-1:0]     col, last_col, start_last_col;
  logic [ROW_W-1:0]     row;
  logic [ADDR_W-1:0]    row_base;
  logic [CODE_W-1:0]    code_q;
  logic                 start, advance, frame_end, pix_last;

  assign scroll_clamped = (scroll_x > MAX_SCROLL) ? MAX_SCROLL : scroll_x;
  // A non-zero fine offset exposes one extra, partially visible column.
  assign start_last_col = (scroll_clamped[TILE_LOG2-1:0] != '0) ? COL_W'(SCREEN_COLS)
                                                               : COL_W'(SCREEN_COLS - 1);
  assign coarse         = scroll_q >> TILE_LOG2;
  assign frame_end      = (col == last_col) && (row == ROW_W'(MAP_ROWS - 1));
  assign level_address  = ADDR_W'(coarse) + ADDR_W'(col) + row_base;
  assign done           = (state == ST_IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    advance    = 1'b0;
    case (state)
      ST_IDLE: if (enable) begin
        state_next = ST_MAP;
        start      = 1'b1;
      end
      ST_MAP:  state_next = ST_CODE;
      ST_CODE: if (tile_code != CODE_W'(SKIP_CODE)) state_next = ST_PIX;
               else advance = 1'b1;
      ST_PIX:  if (pix_last) advance = 1'b1;
      default: state_next = ST_IDLE;
    endcase
    if (advance) state_next = frame_end ? ST_IDLE : ST_MAP;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      scroll_q <= '0;
      last_col <= '0;
      col      <= '0;
      row      <= '0;
      row_base <= '0;
      code_q   <= '0;
    end else begin
      if (start) begin
        scroll_q <= scroll_clamped;
        last_col <= start_last_col;
        col      <= '0;
        row      <= '0;
        row_base <= '0;
      end else if (advance) begin
        if (frame_end) begin
          col      <= '0;
          row      <= '0;
          row_base <= '0;
        end else if (col == last_col) begin
          col      <= '0;
          row      <= row + ROW_W'(1);
          row_base <= row_base + ADDR_W'(TILEMAP_LEN);
        end else begin
          col <= col + COL_W'(1);
        end
      end
      if (state == ST_CODE) code_q <= tile_code;
    end
  end

  tile_pixel_stream #(
    .TILE_LOG2  (TILE_LOG2),
    .CODE_W     (CODE_W),
    .COLOR_DEPTH(COLOR_DEPTH),
    .SCREEN_COLS(SCREEN_COLS),
    .COL_W      (COL_W),
    .ROW_W      (ROW_W)
  ) u_pix (
    .clock       (clock),
    .resetn      (resetn),
    .run         (state == ST_PIX),
    .code        (code_q),
    .col         (col),
    .row         (row),
    .fine        (scroll_q[TILE_LOG2-1:0]),
    .tile_data   (tile_data),
    .tile_address(tile_address),
    .x           (x),
    .y           (y),
    .color       (color),
    .plot        (plot),
    .last        (pix_last)
  );

endmodule

// File: tb/tb_draw_tilemap_scroll.sv
// Directed bench: a frame model fills a scoreboard of expected pixels that a
// negedge monitor pops as the renderer plots them.
module tb_draw_tilemap_scroll;

  localparam int M_ONES = 0, M_SKIP = 1, M_MIXED = 2;

  logic        clock = 1'b0;
  logic        resetn, enable;
  logic [13:0] scroll_x;
  logic [3:0]  tile_code;
  logic [8:0]  tile_data;
  logic [14:0] level_address;
  logic [9:0]  tile_address;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [8:0]  color;
  logic        plot, done;

  int          n_checks = 0, n_pass = 0, n_fail = 0;
  int          mode = M_ONES;
  bit          mon_en = 1'b1;
  logic [23:0] sb[$];

  draw_tilemap_scroll dut (
    .clock(clock), .resetn(resetn), .enable(enable), .scroll_x(scroll_x),
    .tile_code(tile_code), .tile_data(tile_data), .level_address(level_address),
    .tile_address(tile_address), .x(x), .y(y), .color(color), .plot(plot), .done(done)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] code_at(input int a, input int md);
    if (md == M_ONES) return 4'd1;
    if (md == M_SKIP) return 4'd0;
    if (a % 3 == 1) return 4'd0;
    return 4'((a * 7) % 15 + 1);
  endfunction

  function automatic logic [8:0] tset(input int a);
    return 9'((a * 37 + 11) ^ (a >> 2));
  endfunction

  // One-cycle-latency level and tileset memories.
  always @(posedge clock) begin
    tile_code <= code_at(int'(level_address), mode);
    tile_data <= tset(int'(tile_address));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en && plot === 1'b1) begin
      check("plot_pending", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        logic [23:0] e;
        e = sb.pop_front();
        check("x", x, e[23:16]);
        check("y", y, e[15:9]);
        check("color", color, e[8:0]);
      end
    end
  end

  task automatic build_expect(input int s, input int md, output int lat);
    int sc, coarse, fine, nc, addr, sx, c4;
    sc     = (s > 15840) ? 15840 : s;
    coarse = sc >> 3;
    fine   = sc & 7;
    nc     = (fine != 0) ? 21 : 20;
    lat    = 1;
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < nc; c++) begin
        addr = (coarse + c + r * 2000) & 32'h7fff;
        c4   = int'(code_at(addr, md));
        if (c4 == 0) lat += 2;
        else begin
          lat += 66;
          for (int py = 0; py < 8; py++)
            for (int px = 0; px < 8; px++) begin
              sx = c * 8 + px - fine;
              if (sx >= 0 && sx < 160)
                sb.push_back({8'(sx), 7'(r * 8 + py), tset(c4 * 64 + py * 8 + px)});
            end
        end
      end
  endtask

  task automatic run_frame(input logic [13:0] s, input int md, input int probe,
                           input int probe_addr, input logic [13:0] s_late);
    int exp_lat, n;
    mode = md;
    build_expect(int'(s), md, exp_lat);
    @(negedge clock);
    scroll_x = s;
    enable   = 1'b1;
    @(posedge clock);
    #1 enable = 1'b0;
    n = 0;
    check("busy", done, 0);
    if (probe == 0) check("probe_addr", level_address, probe_addr);
    while (done !== 1'b1 && n < 30000) begin
      @(posedge clock);
      #1 n++;
      if (n == 3) scroll_x = s_late;
      if (n == probe) check("probe_addr", level_address, probe_addr);
    end
    check("done_latency", n + 1, exp_lat);
    @(negedge clock);
    #1 check("queue_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    resetn   = 1'b0;
    enable   = 1'b0;
    scroll_x = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_plot", plot, 0);
    check("rst_done", done, 1);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_color", color, 0);
    check("rst_level_addr", level_address, 0);
    check("rst_tile_addr", tile_address, 0);
    @(negedge clock) resetn = 1'b1;

    run_frame(14'd0, M_MIXED, 0, 0, 14'd0);
    run_frame(14'd3, M_ONES, 66 * 20, 20, 14'd3);
    run_frame(14'd16000, M_SKIP, 78, 3999, 14'd16000);
    run_frame(14'd0, M_ONES, 66 * 299, 28019, 14'd0);

    // Abort a frame mid-PIX; no plot may follow the reset.
    mon_en = 1'b0;
    mode   = M_ONES;
    @(negedge clock);
    scroll_x = 14'd5;
    enable   = 1'b1;
    @(posedge clock);
    #1 enable = 1'b0;
    repeat (100) @(posedge clock);
    @(negedge clock) resetn = 1'b0;
    #1 mon_en = 1'b1;
    check("abort_plot", plot, 0);
    check("abort_done", done, 1);
    check("abort_level_addr", level_address, 0);
    check("abort_tile_addr", tile_address, 0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (30) @(posedge clock);
    #1 check("idle_after_reset", done, 1);

    run_frame(14'd8, M_SKIP, 10, 6, 14'd40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
